// File: rtl/key_pkg.sv
// Shared definitions for key-input blocks: channel FSM encoding and default
// timing constants for a 50 MHz system clock.
package key_pkg;

  typedef enum logic [1:0] {
    KEY_IDLE         = 2'd0,
    KEY_PRESS_WAIT   = 2'd1,
    KEY_HELD         = 2'd2,
    KEY_RELEASE_WAIT = 2'd3
  } key_fsm_e;

  // 20 ms debounce window and 1 s long-press time at 50 MHz
  localparam int KEY_DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int KEY_DEFAULT_LONG_CYCLES     = 50000000;
  localparam int KEY_SYNC_STAGES             = 2;

endpackage

// File: rtl/key_channel.sv
// One debounced key channel: 2-flop synchroniser, press/hold/release FSM and
// a shared debounce/long-press counter with registered event pulses.
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = KEY_DEFAULT_LONG_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int CW = $clog2(LONG_CYCLES);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

  logic [KEY_SYNC_STAGES-1:0] sync;
  logic                       s;

  key_fsm_e      state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          long_done, long_done_next;
  logic          key_state_next;
  logic          press_next, release_next, long_next;

  // Synchroniser resets to the released pin level so reset never looks like a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {KEY_SYNC_STAGES{ACTIVE_LOW}};
    end else begin
      sync <= {sync[KEY_SYNC_STAGES-2:0], key};
    end
  end

  assign s = sync[KEY_SYNC_STAGES-1] ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= KEY_IDLE;
      cnt           <= '0;
      long_done     <= 1'b0;
      key_state     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      long_done     <= long_done_next;
      key_state     <= key_state_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      long_pulse    <= long_next;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    long_done_next = long_done;
    unique case (state)
      KEY_IDLE: begin
        if (s) begin
          state_next = KEY_PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      KEY_PRESS_WAIT: begin
        if (!s) begin
          state_next = KEY_IDLE;
          cnt_next   = '0;
        end else if (cnt == DEB_LAST) begin
          state_next = KEY_HELD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      KEY_HELD: begin
        if (cnt == LONG_LAST && !long_done) begin
          long_done_next = 1'b1;
        end
        if (!s) begin
          state_next = KEY_RELEASE_WAIT;
          cnt_next   = '0;
        end else if (cnt != LONG_LAST) begin
          cnt_next = cnt + CW'(1);
        end
      end
      KEY_RELEASE_WAIT: begin
        // A bounce back to pressed keeps long_done so one press gives one long event
        if (s) begin
          state_next = KEY_HELD;
          cnt_next   = '0;
        end else if (cnt == DEB_LAST) begin
          state_next     = KEY_IDLE;
          cnt_next       = '0;
          long_done_next = 1'b0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = KEY_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    press_next     = (state == KEY_PRESS_WAIT) && s && (cnt == DEB_LAST);
    release_next   = (state == KEY_RELEASE_WAIT) && !s && (cnt == DEB_LAST);
    long_next      = (state == KEY_HELD) && (cnt == LONG_LAST) && !long_done;
    key_state_next = key_state;
    if (press_next) begin
      key_state_next = 1'b1;
    end else if (release_next) begin
      key_state_next = 1'b0;
    end
  end

endmodule

// File: rtl/multi_key_debounce.sv
// Bank of N_KEYS independent debounced key channels with press, release and
// long-press event pulses.
module multi_key_debounce
  import key_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = KEY_DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = KEY_DEFAULT_LONG_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .key          (key[i]),
      .key_state    (key_state[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i])
    );
  end

endmodule

// File: doc/multi_key_debounce.md
MULTI_KEY_DEBOUNCE -- requirements
Module: multi_key_debounce

Interface
REQ-001 Parameter N_KEYS, default 4: number of independent key channels, legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: stability window in clk cycles (20 ms at 50 MHz); must be >= 2.
REQ-003 Parameter LONG_CYCLES, default 50000000: hold time for a long-press event (1 s at 50 MHz); must be greater than DEBOUNCE_CYCLES.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 means a pressed key reads 0 on key; 0 means a pressed key reads 1.
REQ-005 clk  input  1  single system clock, 50 MHz nominal; all logic on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 key  input  N_KEYS  raw asynchronous key pins, one bit per channel.
REQ-008 key_state  output  N_KEYS  debounced level per channel; 1 = pressed.
REQ-009 press_pulse  output  N_KEYS  one-cycle pulse on each debounced press.
REQ-010 release_pulse  output  N_KEYS  one-cycle pulse on each debounced release.
REQ-011 long_pulse  output  N_KEYS  one-cycle pulse when a press has been held for LONG_CYCLES.

Function
REQ-012 Each key bit SHALL pass through a 2-flop synchroniser; s = synchronised bit XOR ACTIVE_LOW, so s = 1 means pressed.
REQ-013 Channels SHALL be fully independent; simultaneous activity on any channels has no cross-effect.
REQ-014 Each channel SHALL run an FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, plus one counter sized $clog2(LONG_CYCLES) bits.
REQ-015 IDLE: when s = 1, go to PRESS_WAIT and set cnt = 0.
REQ-016 PRESS_WAIT: when s = 0, return to IDLE (bounce rejected, no pulse); otherwise increment cnt.
REQ-017 PRESS_WAIT: when cnt = DEBOUNCE_CYCLES-1 and s = 1, go to HELD, set key_state = 1, pulse press_pulse and set cnt = 0.
REQ-018 Press latency SHALL be exactly DEBOUNCE_CYCLES+3 rising edges from the key change to press_pulse high (2 synchroniser edges + 1 IDLE exit + DEBOUNCE_CYCLES count).
REQ-019 HELD: cnt increments and saturates at LONG_CYCLES-1.
REQ-020 HELD: when cnt reaches LONG_CYCLES-1 and long_done = 0, pulse long_pulse once and set long_done = 1.
REQ-021 HELD: when s = 0, go to RELEASE_WAIT with cnt = 0.
REQ-022 RELEASE_WAIT: when s = 1, return to HELD with cnt = 0; long_done is kept, so at most one long_pulse per press.
REQ-023 RELEASE_WAIT: when cnt = DEBOUNCE_CYCLES-1 and s = 0, go to IDLE, set key_state = 0, pulse release_pulse, and clear long_done.
REQ-024 Release latency SHALL equal press latency (DEBOUNCE_CYCLES+3 edges).
REQ-025 press_pulse, release_pulse and long_pulse SHALL be registered, high for exactly one cycle, and never high together on one channel.
REQ-026 key_state SHALL change only in the same cycle as press_pulse or release_pulse on that channel.

Reset
REQ-027 While rst_n = 0: synchroniser flops = inactive level (1 if ACTIVE_LOW, else 0), FSM = IDLE, cnt = 0, long_done = 0, all outputs = 0.
REQ-028 Reset asserted mid-debounce or mid-hold SHALL clear that state immediately, with no event emitted.
REQ-029 After reset release, a key already held SHALL be handled as a fresh press: press_pulse after DEBOUNCE_CYCLES+3 edges.

Structure
REQ-030 The FSM state encodings (2-bit) and the default timing constants SHALL live in a shared header/package key_pkg, reused by future key blocks.
REQ-031 Per-channel logic SHALL be a sub-module key_channel (synchroniser, FSM, counter), instantiated N_KEYS times by a generate loop in the top level.

Verification
REQ-032 Benches SHALL override DEBOUNCE_CYCLES = 4 and LONG_CYCLES = 16.
REQ-033 Clean press then release on key[0] (ACTIVE_LOW = 1): key[0] falls -> press_pulse[0] high after edge 7 and key_state[0] = 1; key[0] rises -> release_pulse[0] after edge 7.
REQ-034 Bounce rejection: key[1] low for 2 cycles, high for 1 cycle, repeated 3 times, then high -> no pulses and key_state[1] = 0 throughout.
REQ-035 Long press: hold key[2] low for 40 cycles -> exactly one press_pulse, then exactly one long_pulse 16 edges after press_pulse, then no further long_pulse; release -> one release_pulse.
REQ-036 Release glitch during HELD: a 2-cycle high blip on key[2] after long_pulse -> no release_pulse and no second long_pulse; key_state[2] stays 1.
REQ-037 Simultaneous press on all 4 channels plus rst_n pulsed low mid-PRESS_WAIT -> all outputs 0 at once and no pulses; presses still held after reset -> 4 concurrent press_pulses 7 edges after release of rst_n.
